sub_share_arbiter: RTL and testbench

//  Shares one 16-bit ripple-borrow subtractor (rca_sub) between NREQ requesters.

---
 rtl/sub_arb_pkg.sv | 30 +++
 rtl/rca_sub.sv | 30 +++
 rtl/rr_pick.sv | 37 +++
 rtl/sub_share_arbiter.sv | 132 +++++++++++++
 tb/tb_sub_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sub_arb_pkg.sv
// Shared definitions for the subtractor-sharing arbiter.
//   DW        operand width of the shared subtractor (fixed at 16)
//   NREQ_MAX  largest supported requester count
//   id_width  requester-id width for a given requester count
//   lock_state_t  UNLOCKED (round-robin) / LOCKED (burst owner holds grant)
//   result_t  contents of the registered result port
package sub_arb_pkg;

    localparam int DW       = 16;
    localparam int NREQ_MAX = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_MAX = id_width(NREQ_MAX);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic [DW-1:0]      diff;
        logic               bout;
        logic [IDW_MAX-1:0] id;
        logic               last;
    } result_t;

endpackage

// File: rtl/rca_sub.sv
// 16-bit ripple-borrow subtractor, purely combinational.
//   a, b  minuend / subtrahend
//   bin   borrow-in
//   diff  a - b - bin (modulo 2^16)
//   bout  borrow-out of the most significant bit
module rca_sub
    import sub_arb_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          bin,
    output logic [DW-1:0] diff,
    output logic          bout
);

    logic [DW:0] br;

    always_comb begin
        br    = '0;
        diff  = '0;
        br[0] = bin;
        for (int unsigned i = 0; i < DW; i++) begin
            diff[i]  = a[i] ^ b[i] ^ br[i];
            br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
    end

    assign bout = br[DW];

endmodule

// File: rtl/rr_pick.sv
// Round-robin priority picker.
//   valid  request vector
//   ptr    index of the highest-priority requester this cycle
//   grant  one-hot grant (zero when nothing is valid)
//   gid    index of the granted requester (0 when nothing is valid)
module rr_pick
    import sub_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gid
);

    logic          found;
    logic [IW-1:0] sel;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sel = IW'((32'(ptr) + k) % N);
            if (!found && valid[sel]) begin
                grant[sel] = 1'b1;
                gid        = sel;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one 16-bit subtractor between NREQ requesters with round-robin
// arbitration and multi-word bursts (borrow chained word to word).
//   clk, rst             clock / asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a, req_b         packed operand words, requester i at [i*DW +: DW]
//   req_bin              borrow-in for the first word of a burst
//   req_last             last (or only) word of a burst
//   res_valid/res_ready  result handshake
//   res_diff, res_bout   a - b - borrow and its borrow-out
//   res_id, res_last     issuing requester and its last flag
module sub_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int IDW  = sub_arb_pkg::id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ-1:0]   req_bin,
    input  logic [NREQ-1:0]   req_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_diff,
    output logic              res_bout,
    output logic [IDW-1:0]    res_id,
    output logic              res_last
);

    import sub_arb_pkg::*;

    lock_state_t     state, state_next;
    logic [IDW-1:0]  owner, owner_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gid;
    logic            chain_borrow;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            slot_free;
    logic            accept;
    logic [DW-1:0]   op_a, op_b, sub_diff;
    logic            op_bin, sub_bout;
    result_t         res_q;
    logic            unused_id_bits;

    // While a burst is open only its owner may be granted, even when idle.
    always_comb begin
        owner_mask = '0;
        owner_mask[owner] = 1'b1;
        eligible = req_valid;
        if (state == LOCKED) begin
            eligible = req_valid & owner_mask;
        end
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid (eligible),
        .ptr   (ptr),
        .grant (grant),
        .gid   (gid)
    );

    assign slot_free = !res_valid || res_ready;
    assign req_ready = (slot_free && !rst) ? grant : '0;
    assign accept    = |req_ready;

    assign op_a   = req_a[gid*DW +: DW];
    assign op_b   = req_b[gid*DW +: DW];
    assign op_bin = (state == LOCKED) ? chain_borrow : req_bin[gid];

    rca_sub u_sub (
        .a    (op_a),
        .b    (op_b),
        .bin  (op_bin),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    always_comb begin
        state_next = state;
        owner_next = owner;
        if (accept) begin
            owner_next = gid;
            state_next = req_last[gid] ? UNLOCKED : LOCKED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_q        <= '0;
            chain_borrow <= 1'b0;
            ptr          <= '0;
        end else if (accept) begin
            // A drain in the same cycle is absorbed: the new word overwrites.
            res_valid    <= 1'b1;
            res_q.diff   <= sub_diff;
            res_q.bout   <= sub_bout;
            res_q.id     <= IDW_MAX'(gid);
            res_q.last   <= req_last[gid];
            chain_borrow <= sub_bout;
            ptr          <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
        end else if (res_ready) begin
            res_valid    <= 1'b0;
        end
    end

    assign res_diff = res_q.diff;
    assign res_bout = res_q.bout;
    assign res_id   = res_q.id[IDW-1:0];
    assign res_last = res_q.last;

    // Upper id bits are zero padding when NREQ < NREQ_MAX.
    assign unused_id_bits = ^res_q.id;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed testbench for sub_share_arbiter with a queue scoreboard:
// stimulus pushes expected words, a monitor pops them on each drained result.
module tb_sub_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_bin;
    logic [NREQ-1:0]    req_last;
    logic               res_valid;
    logic               res_ready;
    logic [DW-1:0]      res_diff;
    logic               res_bout;
    logic [IDW-1:0]     res_id;
    logic               res_last;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic [1:0]  id;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   acc;

    sub_share_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_bin   (req_bin),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_diff  (res_diff),
        .res_bout  (res_bout),
        .res_id    (res_id),
        .res_last  (res_last)
    );

    always #5 clk = ~clk;

    // Monitor: every word that drains this cycle must match the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got diff=%h bout=%b id=%0d last=%b, none required",
                         res_diff, res_bout, res_id, res_last);
            end else begin
                mon_e = sb.pop_front();
                if ({res_diff, res_bout, res_id, res_last} !== mon_e) begin
                    miscompares++;
                    $display("FAIL result: got diff=%h bout=%b id=%0d last=%b, required diff=%h bout=%b id=%0d last=%b",
                             res_diff, res_bout, res_id, res_last,
                             mon_e.diff, mon_e.bout, mon_e.id, mon_e.last);
                end
            end
        end
    end

    task automatic expect_word(input logic [15:0] d, input logic bo,
                               input logic [1:0] id, input logic l);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.id   = id;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic load(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic last);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_bin[i]        = bin;
        req_last[i]       = last;
    endtask

    // Called just after a rising edge; returns just after the edge of acceptance.
    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic last);
        int n;
        n = 0;
        load(i, a, b, bin, last);
        req_valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 50);
        if (!req_ready[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: req%0d not accepted, required accept within 50 cycles", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_bin   = '0;
        req_last  = '1;
        res_ready = 1'b1;

        // Reset state, with every requester asking
        repeat (2) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_res_fields", {res_diff, res_bout, res_id, res_last}, 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;

        // Single word and underflow cases
        expect_word(16'h0002, 1'b0, 2'd0, 1'b1);
        send(0, 16'h0005, 16'h0003, 1'b0, 1'b1);
        expect_word(16'hFFFF, 1'b1, 2'd0, 1'b1);
        send(0, 16'h0000, 16'h0001, 1'b0, 1'b1);
        expect_word(16'hFFFF, 1'b1, 2'd1, 1'b1);
        send(1, 16'h1234, 16'h1234, 1'b1, 1'b1);
        wait_drain();

        // 32-bit burst on req2 with an idle cycle; req1 waits throughout.
        // Second word carries bin=0 so only the chained borrow gives 0x0000.
        expect_word(16'hFFFF, 1'b1, 2'd2, 1'b0);
        expect_word(16'h0000, 1'b0, 2'd2, 1'b1);
        expect_word(16'h000F, 1'b0, 2'd1, 1'b1);
        fork
            begin
                send(2, 16'h0000, 16'h0001, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                send(2, 16'h0001, 16'h0000, 1'b0, 1'b1);
            end
            send(1, 16'h0010, 16'h0001, 1'b0, 1'b1);
        join
        wait_drain();

        // All four requesting continuously: rotation and full throughput
        reset_pulse();
        for (int i = 0; i < 2; i++) begin
            expect_word(16'h00FF, 1'b0, 2'd0, 1'b1);
            expect_word(16'h01FE, 1'b0, 2'd1, 1'b1);
            expect_word(16'h02FD, 1'b0, 2'd2, 1'b1);
            expect_word(16'h03FC, 1'b0, 2'd3, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            load(i, 16'(16'h0100 * (i + 1)), 16'(i + 1), 1'b0, 1'b1);
        end
        req_valid = '1;
        acc = 0;
        repeat (8) begin
            @(negedge clk);
            if (|req_ready) acc++;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        check("rotation_accepts_in_8_cycles", 64'(acc), 64'd8);
        wait_drain();

        // Back-pressure: result held for 3 cycles, then resume with no bubble
        expect_word(16'h00F0, 1'b0, 2'd0, 1'b1);
        expect_word(16'h0002, 1'b0, 2'd1, 1'b1);
        res_ready = 1'b0;
        load(0, 16'h00FF, 16'h000F, 1'b0, 1'b1);
        load(1, 16'h0003, 16'h0001, 1'b0, 1'b1);
        req_valid = 4'b0011;
        @(negedge clk);
        check("stall_first_grant", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_held_result", {res_valid, res_diff, res_bout, res_id, res_last},
                  {1'b1, 16'h00F0, 1'b0, 2'd0, 1'b1});
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("release_accept_same_cycle", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset in the middle of a burst that left borrow=1 and ptr=1
        res_ready = 1'b0;
        send(0, 16'h0000, 16'h0001, 1'b0, 1'b0);
        check("midburst_word_held", 64'(res_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midburst_reset_res_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        expect_word(16'h000F, 1'b0, 2'd0, 1'b1);
        expect_word(16'hFFFF, 1'b1, 2'd3, 1'b1);
        fork
            send(0, 16'h0010, 16'h0001, 1'b0, 1'b1);
            send(3, 16'h0100, 16'h0100, 1'b1, 1'b1);
        join
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
